serial_add_seq: RTL and testbench
=================================

// Module: serial_add_seq
// PURPOSE
// - Bit-serial adder that sits directly downstream of the operand source and
//   consumes the halfadd_d primitive.
// - Accepts two WIDTH-bit operands over a valid/ready handshake, then adds
//   them LSB-first, one bit per clock.
// - Each bit uses a full adder built from two halfadd_d instances and an
//   OR gate; the carry between bits is kept in a flop.
// - Returns the WIDTH-bit sum and the carry-out over a valid/ready handshake.
// - Trades latency for area in the team's adder family.
// PARAMETERS
// - WIDTH  8  Operand and sum width in bits. Legal range is >= 2.
// PORTS
// - clk        in   1      Rising-edge clock.
// - rst_n      in   1      Asynchronous active-low reset.
// - in_valid   in   1      Operands a_in and b_in are valid.
// - in_ready   out  1      Block can accept operands (high only in IDLE).
// - a_in       in   WIDTH  Operand A, unsigned or two's complement.
// - b_in       in   WIDTH  Operand B.
// - out_valid  out  1      sum, cout and ovf are valid (high only in DONE).
// - out_ready  in   1      Consumer accepts the result.
// - sum        out  WIDTH  (a_in + b_in) mod 2^WIDTH.
// - cout       out  1      Carry out of bit WIDTH-1.
// - ovf        out  1      Signed overflow. Tied 0 unless SERIAL_ADD_OVF_EN.
// BEHAVIOUR
// - Reset is asynchronous and active-low; the rest of the block is
//   synchronous to the rising edge of clk.
// - While rst_n is low: state=IDLE, A/B/sum shift registers=0, carry=0,
//   count=0, cout=0, ovf=0, in_ready=1, out_valid=0.
// - IDLE: in_ready=1. On an edge with in_valid=1:
//     - load A<=a_in, B<=b_in, carry<=0, count<=0;
//     - go to BUSY.
// - BUSY: in_ready=0 and out_valid=0. Each edge processes one bit:
//     - ha0 = halfadd(A[0], B[0]); ha1 = halfadd(ha0.s, carry);
//     - sum <= {ha1.s, sum[WIDTH-1:1]};
//     - carry <= ha0.c | ha1.c;
//     - A and B shift right by 1; count increments.
//   On the edge where count==WIDTH-1: cout<=new carry, go to DONE.
// - DONE: out_valid=1. sum, cout and ovf are held stable until an edge with
//   out_ready=1; on that edge go to IDLE.
// - in_ready=0 in DONE, so a new operand pair cannot be taken on the same
//   edge as the result handshake.
// - Latency: out_valid rises exactly WIDTH edges after the input-accept edge.
// - Minimum initiation interval: WIDTH+2 cycles.
// - in_valid in BUSY or DONE is ignored; a_in and b_in are not sampled.
// - out_ready in IDLE or BUSY has no effect.
// - Carry is cleared at every load, so nothing leaks between operations.
// - Wrap-around: the sum is modulo 2^WIDTH; the lost bit appears only on cout.
// - Reset asserted mid-BUSY or mid-DONE aborts the operation:
//     - all state returns to reset values immediately;
//     - no result is presented.
// - count width is $clog2(WIDTH). No combinational path from in_* to out_*.
// CONFIGURATION
// - Macro SERIAL_ADD_OVF_EN:
//     - Defined: a carry_msb flop captures the carry into bit WIDTH-1 on the
//       edge count==WIDTH-2. On the final BUSY edge,
//       ovf <= carry_msb ^ carry_out. ovf is held with sum and reset to 0.
//     - Undefined: ovf is constant 0 and the flop is not built.
// TESTING
// - All scenarios use WIDTH=8 with SERIAL_ADD_OVF_EN defined.
// - Basic add: 8'h25 + 8'h13 -> after exactly 8 edges, out_valid=1,
//   sum=8'h38, cout=0, ovf=0.
// - Wrap-around: 8'hFF + 8'h01 -> sum=8'h00, cout=1, ovf=0.
// - Signed overflow: 8'h7F + 8'h01 -> sum=8'h80, cout=0, ovf=1.
//   Rebuild without the macro: same sum and cout, ovf=0.
// - Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1
//   and sum/cout stay stable. out_ready=1 -> next edge IDLE, in_ready=1.
// - Ignored input: pulse in_valid with 8'hAA/8'h55 during BUSY of 8'h01+8'h01
//   -> result is sum=8'h02; the next accept happens only in IDLE.
// - Reset mid-op: deassert rst_n 3 edges into BUSY -> outputs are at reset
//   values immediately. After release, 8'h80+8'h80 -> sum=8'h00, cout=1,
//   ovf=1.

Source files
------------

// File: rtl/serial_add_seq.sv
// Bit-serial LSB-first adder with valid/ready handshakes on both sides.
// Optional signed-overflow flag built when SERIAL_ADD_OVF_EN is defined.

module halfadd_d (
    input  logic i_a,
    input  logic i_b,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b;
    assign o_c = i_a & i_b;
endmodule

module serial_add_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST      = CW'(WIDTH - 1);
    localparam logic [CW-1:0] NEXT_LAST = CW'(WIDTH - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic [CW-1:0]    r_count;
    logic             r_cout;

    logic w_s0;
    logic w_c0;
    logic w_s1;
    logic w_c1;
    logic w_carry_nxt;

    halfadd_d u_ha0 (
        .i_a (r_a[0]),
        .i_b (r_b[0]),
        .o_s (w_s0),
        .o_c (w_c0)
    );

    halfadd_d u_ha1 (
        .i_a (w_s0),
        .i_b (r_carry),
        .o_s (w_s1),
        .o_c (w_c1)
    );

    assign w_carry_nxt = w_c0 | w_c1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = BUSY;
            end
            BUSY: begin
                if (r_count == LAST) w_state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // One sum bit per BUSY edge; operands shift right so bit 0 is always current.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_count <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a_in;
                        r_b     <= b_in;
                        r_carry <= 1'b0;
                        r_count <= '0;
                    end
                end
                BUSY: begin
                    r_sum   <= {w_s1, r_sum[WIDTH-1:1]};
                    r_carry <= w_carry_nxt;
                    r_a     <= {1'b0, r_a[WIDTH-1:1]};
                    r_b     <= {1'b0, r_b[WIDTH-1:1]};
                    r_count <= r_count + 1'b1;
                    if (r_count == LAST) r_cout <= w_carry_nxt;
                end
                default: ;
            endcase
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

`ifdef SERIAL_ADD_OVF_EN
    logic r_carry_msb;
    logic r_ovf;

    // Overflow when the carry into the MSB differs from the carry out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_carry_msb <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (r_state == BUSY) begin
            if (r_count == NEXT_LAST) r_carry_msb <= w_carry_nxt;
            if (r_count == LAST)      r_ovf       <= r_carry_msb ^ w_carry_nxt;
        end
    end

    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_add_seq.sv
// Directed bench for serial_add_seq (WIDTH=8); ovf is expected only when
// SERIAL_ADD_OVF_EN is defined, otherwise it must read 0.

module tb_serial_add_seq;
    localparam int WIDTH = 8;

`ifdef SERIAL_ADD_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int n_checks = 0;
    int n_fail   = 0;

    serial_add_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands, take the accept edge, drop in_valid afterwards.
    task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        a_in     = a;
        b_in     = b;
        in_valid = 1'b1;
        #1;
        check("accept_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("busy_ready", in_ready, 0);
    endtask

    // Counts edges after accept until out_valid; bounded.
    task automatic wait_done(input string tag);
        int edges;
        edges = 0;
        while (!out_valid && edges < 20) begin
            tick();
            edges++;
        end
        check({tag, "_latency"}, edges, WIDTH);
    endtask

    task automatic check_result(input string tag, input logic [WIDTH-1:0] es,
                                input logic ec, input logic eo);
        check({tag, "_sum"},  sum,  es);
        check({tag, "_cout"}, cout, ec);
        check({tag, "_ovf"},  ovf,  OVF_ON ? eo : 1'b0);
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_idle_ready"}, in_ready, 1);
        check({tag, "_idle_valid"}, out_valid, 0);
    endtask

    initial begin
        logic [WIDTH-1:0] held_sum;
        logic             held_cout;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_in      = '0;
        b_in      = '0;
        #12;
        check("rst_in_ready",  in_ready,  1);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum",       sum,       0);
        check("rst_cout",      cout,      0);
        check("rst_ovf",       ovf,       0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Basic add
        start_op(8'h25, 8'h13);
        wait_done("basic");
        check_result("basic", 8'h38, 1'b0, 1'b0);
        release_result("basic");

        // Wrap-around
        start_op(8'hFF, 8'h01);
        wait_done("wrap");
        check_result("wrap", 8'h00, 1'b1, 1'b0);
        release_result("wrap");

        // Signed overflow
        start_op(8'h7F, 8'h01);
        wait_done("sovf");
        check_result("sovf", 8'h80, 1'b0, 1'b1);

        // Backpressure: result of 7F+01 held while out_ready is low
        held_sum  = sum;
        held_cout = cout;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", out_valid, 1);
            check("bp_sum",   sum,       held_sum);
            check("bp_cout",  cout,      held_cout);
            check("bp_ready", in_ready,  0);
        end
        release_result("bp");

        // Ignored input during BUSY and DONE
        start_op(8'h01, 8'h01);
        a_in     = 8'hAA;
        b_in     = 8'h55;
        in_valid = 1'b1;
        wait_done("ign");
        check_result("ign", 8'h02, 1'b0, 1'b0);
        check("ign_done_ready", in_ready, 0);
        release_result("ign");
        tick();
        in_valid = 1'b0;
        check("ign_accept_idle", in_ready, 0);
        wait_done("ign2");
        check_result("ign2", 8'hFF, 1'b0, 1'b0);
        release_result("ign2");

        // Reset mid-operation
        start_op(8'h12, 8'h34);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_ready", in_ready,  1);
        check("mid_rst_sum",   sum,       0);
        check("mid_rst_cout",  cout,      0);
        check("mid_rst_ovf",   ovf,       0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_valid", out_valid, 0);
        start_op(8'h80, 8'h80);
        wait_done("neg");
        check_result("neg", 8'h00, 1'b1, 1'b1);
        release_result("neg");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
